// File: rtl/midi_wb_pkg.sv
// midi_wb_pkg: register offsets, STATUS/CTRL bit indices and idle read data for wb_midi_rx_fifo
package midi_wb_pkg;
  localparam logic [3:0] REG_DATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_CTRL = 4'h2;
  localparam logic [3:0] REG_COUNT = 4'h3;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_IRQ = 3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam logic [7:0] DAT_IDLE = 8'h00;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO (clk, rst, push/pop/flush, din -> dout head, full/empty/count); flush discards same-cycle push, pop frees a slot for a same-cycle push
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count[DEPTH_LOG2];
  assign do_pop = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (rst | flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + DEPTH_LOG2'(do_push);
      rptr <= rptr + DEPTH_LOG2'(do_pop);
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/wb_midi_rx_fifo.sv
// wb_midi_rx_fifo: Wishbone slave buffering MIDI rx bytes (wb_* bus, rx_data_i/rx_valid_i in, irq_o only with WB_MIDI_RX_IRQ_EN)
module wb_midi_rx_fifo
  import midi_wb_pkg::*;
#(
  parameter int   DEPTH_LOG2 = 4,
  parameter logic RESET_EN_VAL = 1'b1
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i
`ifdef WB_MIDI_RX_IRQ_EN
  ,
  output logic       irq_o
`endif
);
  logic req, rd, wr, pop, flush, push, full, empty, enable, overflow, irq_en, irq_pending, w1c, ovf_set;
  logic unused_bits;
  logic [7:0] head, rdata;
  logic [DEPTH_LOG2:0] count;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd = req & ~wb_we_i;
  assign wr = req & wb_we_i;
  assign pop = rd & wb_addr_i == REG_DATA;
  assign flush = wr & wb_addr_i == REG_CTRL & wb_dat_i[CTRL_FLUSH];
  assign push = rx_valid_i & enable;
  assign ovf_set = push & full & ~pop & ~flush;
  assign w1c = wr & wb_addr_i == REG_STATUS & wb_dat_i[ST_OVF];
  assign irq_pending = irq_en & (~empty | overflow);
  assign unused_bits = ^wb_dat_i;
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(rx_data_i),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb
    rdata = wb_addr_i == REG_DATA   ? (empty ? DAT_IDLE : head) :
            wb_addr_i == REG_STATUS ? {4'b0, irq_pending, overflow, full, empty} :
            wb_addr_i == REG_CTRL   ? {5'b0, irq_en, 1'b0, enable} :
            wb_addr_i == REG_COUNT  ? 8'(count) : DAT_IDLE;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= DAT_IDLE;
      enable <= RESET_EN_VAL;
      overflow <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : DAT_IDLE;
      overflow <= ovf_set | (overflow & ~w1c);
      if (wr & wb_addr_i == REG_CTRL) enable <= wb_dat_i[CTRL_EN];
    end
`ifdef WB_MIDI_RX_IRQ_EN
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_pending;
      if (wr & wb_addr_i == REG_CTRL) irq_en <= wb_dat_i[CTRL_IRQ_EN];
    end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_wb_midi_rx_fifo.sv
// tb_wb_midi_rx_fifo: self-checking bench for wb_midi_rx_fifo against a queue-based register model
module tb_wb_midi_rx_fifo;
  logic wb_clk_i = 0, wb_rst_i = 1, wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0, wb_ack_o, rx_valid_i = 0;
  logic [3:0] wb_addr_i = 0;
  logic [7:0] wb_dat_i = 0, wb_dat_o, rx_data_i = 0;
`ifdef WB_MIDI_RX_IRQ_EN
  logic irq_o;
`endif
  int errors = 0, checks = 0;
  byte unsigned mq[$];
  bit m_ovf = 0, m_en = 1, m_irqen = 0;
  wb_midi_rx_fifo dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i)
`ifdef WB_MIDI_RX_IRQ_EN
    , .irq_o(irq_o)
`endif
  );
  always #5 wb_clk_i = ~wb_clk_i;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic model(input bit we, input logic [3:0] a, input logic [7:0] d, input bit rv, input logic [7:0] rb, output logic [7:0] exp);
    int n = mq.size();
    bit irq = m_irqen & ((n != 0) | m_ovf);
    bit set = 0;
    exp = 8'h00;
    if (!we)
      case (a)
        4'h0: if (n != 0) exp = mq.pop_front();
        4'h1: exp = {4'b0, irq, m_ovf, n == 16, n == 0};
        4'h2: exp = {5'b0, m_irqen, 1'b0, m_en};
        4'h3: exp = 8'(n);
        default: exp = 8'h00;
      endcase
    if (we && a == 4'h2 && d[1]) mq.delete();
    else if (rv && m_en) begin
      if (mq.size() < 16) mq.push_back(rb);
      else begin
        m_ovf = 1;
        set = 1;
      end
    end
    if (we && a == 4'h1 && d[2] && !set) m_ovf = 0;
    if (we && a == 4'h2) begin
      m_en = d[0];
`ifdef WB_MIDI_RX_IRQ_EN
      m_irqen = d[2];
`endif
    end
  endtask
  task automatic xfer(input bit we, input logic [3:0] a, input logic [7:0] d, input bit rv, input logic [7:0] rb, output logic [7:0] got, output logic ack, output logic [7:0] exp);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_addr_i = a; wb_dat_i = d;
    rx_valid_i = rv; rx_data_i = rb;
    model(we, a, d, rv, rb, exp);
    @(posedge wb_clk_i); #1;
    got = wb_dat_o; ack = wb_ack_o;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; rx_valid_i = 0;
  endtask
  task automatic push(input logic [7:0] b);
    @(posedge wb_clk_i); #1;
    rx_valid_i = 1; rx_data_i = b;
    if (m_en) begin
      if (mq.size() < 16) mq.push_back(b);
      else m_ovf = 1;
    end
    @(posedge wb_clk_i); #1;
    rx_valid_i = 0;
  endtask
  task automatic model_reset();
    mq.delete(); m_ovf = 0; m_en = 1; m_irqen = 0;
  endtask
  task automatic test_reset();
    logic [7:0] got, exp;
    logic ack;
    wb_rst_i = 1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got=%h exp=00", wb_dat_o); end
    wb_rst_i = 0; model_reset();
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01 || ack !== 1'b1) begin errors++; $display("FAIL reset_status got=%h ack=%b exp=01", got, ack); end
    xfer(0, 4'h2, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01) begin errors++; $display("FAIL reset_ctrl got=%h exp=01", got); end
    push(8'h11); push(8'h22);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_addr_i = 4'h0; wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_mid_ack got=%b exp=0", wb_ack_o); end
    wb_cyc_i = 0; wb_stb_i = 0; wb_rst_i = 0; model_reset();
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h00) begin errors++; $display("FAIL reset_mid_count got=%h exp=00", got); end
  endtask
  task automatic test_basic();
    logic [7:0] got, exp, want[3];
    logic ack;
    want[0] = 8'h90; want[1] = 8'h3C; want[2] = 8'h64;
    for (int i = 0; i < 3; i++) push(want[i]);
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h03) begin errors++; $display("FAIL basic_count got=%h exp=03", got); end
    for (int i = 0; i < 3; i++) begin
      xfer(0, 4'h0, 0, 0, 0, got, ack, exp);
      checks++; if (got !== want[i] || ack !== 1'b1) begin errors++; $display("FAIL basic_data%0d got=%h ack=%b exp=%h", i, got, ack, want[i]); end
    end
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01) begin errors++; $display("FAIL basic_status got=%h exp=01", got); end
  endtask
  task automatic test_overflow();
    logic [7:0] got, exp;
    logic ack;
    for (int i = 0; i < 17; i++) push(8'(i));
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h06) begin errors++; $display("FAIL ovf_status got=%h exp=06", got); end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 4'h0, 0, 0, 0, got, ack, exp);
      checks++; if (got !== 8'(i)) begin errors++; $display("FAIL ovf_data%0d got=%h exp=%h", i, got, 8'(i)); end
    end
    xfer(1, 4'h1, 8'h04, 0, 0, got, ack, exp);
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01) begin errors++; $display("FAIL ovf_cleared got=%h exp=01", got); end
  endtask
  task automatic test_empty_read();
    logic [7:0] got, exp;
    logic ack;
    logic exp_ack[4];
    exp_ack[0] = 1; exp_ack[1] = 0; exp_ack[2] = 1; exp_ack[3] = 0;
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_addr_i = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      checks++; if (wb_ack_o !== exp_ack[i] || wb_dat_o !== 8'h00) begin errors++; $display("FAIL empty_ack%0d got ack=%b dat=%h exp ack=%b dat=00", i, wb_ack_o, wb_dat_o, exp_ack[i]); end
      if (i == 2) begin wb_cyc_i = 0; wb_stb_i = 0; end
    end
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h00) begin errors++; $display("FAIL empty_count got=%h exp=00", got); end
  endtask
  task automatic test_full_push_pop();
    logic [7:0] got, exp;
    logic ack;
    xfer(1, 4'h2, 8'h03, 0, 0, got, ack, exp);
    xfer(1, 4'h1, 8'h04, 0, 0, got, ack, exp);
    for (int i = 0; i < 16; i++) push(8'($urandom));
    xfer(0, 4'h0, 0, 1, 8'hA5, got, ack, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL full_head got=%h exp=%h", got, exp); end
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h10) begin errors++; $display("FAIL full_count got=%h exp=10", got); end
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h02) begin errors++; $display("FAIL full_status got=%h exp=02", got); end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 4'h0, 0, 0, 0, got, ack, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL full_tail got=%h exp=a5", got); end
  endtask
  task automatic test_flush();
    logic [7:0] got, exp;
    logic ack;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    xfer(1, 4'h2, 8'h03, 1, 8'h77, got, ack, exp);
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h00) begin errors++; $display("FAIL flush_count got=%h exp=00", got); end
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01) begin errors++; $display("FAIL flush_status got=%h exp=01", got); end
    xfer(0, 4'h2, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h01) begin errors++; $display("FAIL flush_ctrl got=%h exp=01", got); end
  endtask
  task automatic test_random();
    logic [7:0] got, exp, d;
    logic ack;
    logic [3:0] a;
    bit we, rv;
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 9);
      rv = $urandom_range(0, 9) < 6;
      if (k < 3) push(8'($urandom));
      else begin
        d = 8'($urandom);
        we = k >= 7;
        a = k < 6 ? 4'h0 : k == 6 ? 4'($urandom) : k == 7 ? 4'h1 : k == 8 ? 4'h2 : 4'($urandom_range(4, 15));
        if (k == 8) d = {d[7:2], 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) != 0)};
        xfer(we, a, d, rv, 8'($urandom), got, ack, exp);
        checks++; if (got !== exp || ack !== 1'b1) begin errors++; $display("FAIL rand%0d we=%b a=%h got=%h ack=%b exp=%h", i, we, a, got, ack, exp); end
      end
    end
    xfer(0, 4'h3, 0, 0, 0, got, ack, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL rand_count got=%h exp=%h", got, exp); end
    xfer(1, 4'h2, 8'h03, 0, 0, got, ack, exp);
    xfer(1, 4'h1, 8'h04, 0, 0, got, ack, exp);
  endtask
`ifdef WB_MIDI_RX_IRQ_EN
  task automatic test_irq();
    logic [7:0] got, exp;
    logic ack;
    xfer(1, 4'h2, 8'h07, 0, 0, got, ack, exp);
    xfer(1, 4'h1, 8'h04, 0, 0, got, ack, exp);
    xfer(0, 4'h2, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h05) begin errors++; $display("FAIL irq_ctrl got=%h exp=05", got); end
    repeat (2) @(posedge wb_clk_i);
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq_o); end
    rx_valid_i = 1; rx_data_i = 8'h90; mq.push_back(8'h90);
    @(posedge wb_clk_i); #1;
    rx_valid_i = 0;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_push_lag got=%b exp=0", irq_o); end
    @(posedge wb_clk_i); #1;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_push got=%b exp=1", irq_o); end
    xfer(0, 4'h1, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h08) begin errors++; $display("FAIL irq_status got=%h exp=08", got); end
    xfer(0, 4'h0, 0, 0, 0, got, ack, exp);
    checks++; if (got !== 8'h90 || irq_o !== 1'b1) begin errors++; $display("FAIL irq_pop_lag got=%h irq=%b exp=90/1", got, irq_o); end
    @(posedge wb_clk_i); #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_pop got=%b exp=0", irq_o); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_read();
    test_full_push_pop();
    test_flush();
    test_random();
`ifdef WB_MIDI_RX_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_midi_rx_fifo.md
Name: wb_midi_rx_fifo

Overview:
Wishbone B4 classic slave that occupies one 16-address block (one 8-bit slice of the coarse read-data selector) and buffers MIDI bytes from the UART receiver.
- Received bytes are pushed into a synchronous FIFO.
- The CPU pops them through a DATA register and monitors fill and overflow through STATUS and COUNT.
- Block-level decode (wb_addr_i[7:4]) is external; this block decodes wb_addr_i[3:0] only.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)
RESET_EN_VAL, 1'b1, reset value of CTRL.enable

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe, qualified by external block select
wb_we_i  in  1  1 = write, 0 = read
wb_addr_i  in  4  register offset within block
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data to the selector slice
wb_ack_o  out  1  transfer acknowledge
rx_data_i  in  8  byte from MIDI UART receiver
rx_valid_i  in  1  single-cycle strobe, rx_data_i valid

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset is synchronous and active-high (wb_rst_i).
- Reset values:
  - wb_ack_o=0, wb_dat_o=8'h00.
  - FIFO empty, count=0, overflow=0.
  - CTRL.enable=RESET_EN_VAL.
  - Reset mid-transaction: ack is dropped and FIFO contents are discarded.
- Register map (offsets in wb_addr_i):
  - 0x0 DATA (R): pops the head byte.
  - 0x1 STATUS (R/W1C): bit0 empty, bit1 full, bit2 overflow (sticky, write 1 clears), bit3 irq_pending.
  - 0x2 CTRL (R/W): bit0 enable, bit1 flush (write-only, self-clearing, reads 0), bit2 irq_en.
  - 0x3 COUNT (R): entries, zero-extended to 8 bits.
  - 0x4–0xF: reads return 8'h00; writes are ignored.
- Handshake:
  - A request is wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o rises exactly one cycle after the request and is high for exactly one cycle. Zero wait states, no back-to-back ack; the master holds stb through ack.
  - wb_dat_o is registered with the request, valid only while wb_ack_o=1, and forced to 8'h00 otherwise so the selector sees a clean zero.
  - Side effects (pop, W1C, flush, CTRL write) take place on the request cycle, once per transfer.
- FIFO push: on rx_valid_i & enable.
  - If full: byte dropped, overflow<=1, contents unchanged.
  - When enable=0, rx_valid_i is ignored and does not set overflow.
- FIFO pop: on a DATA read request.
  - If empty: returns 8'h00, no pointer change, no error flag.
- Simultaneous push and pop:
  - Non-empty: both occur and count is unchanged. When full, the pop frees a slot, so the push succeeds and overflow stays 0.
  - Empty: the push occurs; the pop returns 8'h00.
- Flush:
  - Clears pointers and count in the request cycle; any same-cycle push is discarded.
  - Overflow is not cleared by flush.
- Pointers: DEPTH_LOG2-bit, wrap naturally. count is DEPTH_LOG2+1 bits; full when count==2^DEPTH_LOG2.
- W1C clearing overflow in the same cycle as a new overflow event: the set wins.
- irq_pending = irq_en & (~empty | overflow), combinational from registered state.

Optional Feature:
Macro: WB_MIDI_RX_IRQ_EN
- Defined: adds output port irq_o (1 bit), registered copy of irq_pending with one-cycle latency; reset 0.
- Undefined: no irq_o port. CTRL.bit2 reads as 0 and ignores writes; STATUS.bit3 reads as 0.

Decomposition:
- Package midi_wb_pkg holds:
  - register offsets (REG_DATA, REG_STATUS, REG_CTRL, REG_COUNT)
  - STATUS/CTRL bit indices
  - the 8'h00 idle-data constant
- Sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count) holds the storage and pointers; the top holds decode, ack and control registers.

Test Plan:
- Reset, then push 8'h90, 8'h3C, 8'h64 -> COUNT reads 8'h03; three DATA reads return 90, 3C, 64 in order; STATUS then reads 8'h01.
- Push 17 bytes (8'h00..8'h10) with DEPTH_LOG2=4 -> STATUS reads 8'h06 (full+overflow); DATA reads return 00..0F; write STATUS 8'h04 -> overflow cleared, STATUS reads 8'h01.
- DATA read when empty -> wb_dat_o 8'h00 during ack, COUNT stays 0; wb_ack_o high exactly one cycle per request with stb held 3 cycles.
- FIFO full plus rx_valid_i coincident with DATA read request -> head returned, new byte stored at tail, COUNT stays 16, overflow 0.
- Write CTRL 8'h03 (enable+flush) with 5 entries and a same-cycle push -> COUNT reads 0, STATUS.empty=1, CTRL reads 8'h01.
- WB_MIDI_RX_IRQ_EN defined, CTRL=8'h05, push one byte -> irq_o high one cycle after push; pop -> irq_o low one cycle after the pop.
